// File: rtl/fifo_frame_tx.sv
// Framing stage in front of the byte FIFO: wraps each payload frame as
// FLAG, escaped payload, escaped two's-complement checksum, FLAG.
module fifo_frame_tx #(
  parameter logic [7:0] FLAG    = 8'h7E,
  parameter logic [7:0] ESC     = 8'h7D,
  parameter logic [7:0] ESC_XOR = 8'h20
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, DATA, ESCB, CSUM, CSUM_ESC, EOFR
  } state_t;

  state_t     state, state_n;
  logic [7:0] csum, csum_n;
  logic [7:0] esc_byte, esc_byte_n;
  logic       last_q, last_n;
  logic       fc_inc;
  logic [7:0] ck;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == FLAG) || (b == ESC);
  endfunction

  // Transmitted checksum makes (payload sum + ck) mod 256 == 0.
  assign ck   = ~csum + 8'd1;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      csum        <= '0;
      esc_byte    <= '0;
      last_q      <= 1'b0;
      frame_count <= '0;
    end else begin
      state    <= state_n;
      csum     <= csum_n;
      esc_byte <= esc_byte_n;
      last_q   <= last_n;
      if (fc_inc) frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    state_n    = state;
    csum_n     = csum;
    esc_byte_n = esc_byte;
    last_n     = last_q;
    fc_inc     = 1'b0;
    in_ready   = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    // Outputs stay quiet while reset is held so the FIFO sees no stray write.
    if (!srst) begin
      unique case (state)
        IDLE: begin
          if (in_valid && !fifo_full) begin
            fifo_wr_en = 1'b1;
            fifo_din   = FLAG;
            csum_n     = '0;
            state_n    = DATA;
          end
        end
        DATA: begin
          in_ready = !fifo_full;
          if (in_valid && !fifo_full) begin
            fifo_wr_en = 1'b1;
            csum_n     = csum + in_data;
            if (needs_esc(in_data)) begin
              fifo_din   = ESC;
              esc_byte_n = in_data ^ ESC_XOR;
              last_n     = in_last;
              state_n    = ESCB;
            end else begin
              fifo_din = in_data;
              state_n  = in_last ? CSUM : DATA;
            end
          end
        end
        ESCB: begin
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            fifo_din   = esc_byte;
            state_n    = last_q ? CSUM : DATA;
          end
        end
        CSUM: begin
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            if (needs_esc(ck)) begin
              fifo_din = ESC;
              state_n  = CSUM_ESC;
            end else begin
              fifo_din = ck;
              state_n  = EOFR;
            end
          end
        end
        CSUM_ESC: begin
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            fifo_din   = ck ^ ESC_XOR;
            state_n    = EOFR;
          end
        end
        EOFR: begin
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            fifo_din   = FLAG;
            fc_inc     = 1'b1;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_tx.sv
// Directed bench for fifo_frame_tx: expected FIFO bytes are queued as stimulus
// is applied and checked against every fifo_wr_en cycle.
module tb_fifo_frame_tx;

  logic        clk = 1'b0;
  logic        srst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        busy;
  logic [15:0] frame_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  int unsigned wr_cyc[$];

  fifo_frame_tx #(.FLAG(8'h7E), .ESC(8'h7D), .ESC_XOR(8'h20)) dut (
    .clk(clk), .srst(srst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard side: every FIFO write must match the next queued byte.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      chk("wr_while_full", {31'b0, fifo_full}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_write", {24'b0, fifo_din}, 32'hFFFF_FFFF);
      else chk("fifo_byte", {24'b0, fifo_din}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic push_esc(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [7:0] p[$]);
    logic [7:0] s;
    s = 8'h00;
    exp_q.push_back(8'h7E);
    foreach (p[i]) begin
      s = s + p[i];
      push_esc(p[i]);
    end
    push_esc(8'h00 - s);
    exp_q.push_back(8'h7E);
  endtask

  task automatic push_list(input logic [7:0] l[$]);
    foreach (l[i]) exp_q.push_back(l[i]);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int unsigned n;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'b0, busy}, 32'd0);
    chk("drain_left", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic stall3(input string tag);
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_wr"}, {31'b0, fifo_wr_en}, 32'd0);
      chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    srst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_wr", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_din", {24'b0, fifo_din}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fc", {16'b0, frame_count}, 32'd0);
    @(posedge clk); #1; srst = 1'b0;

    // Plain frame, six consecutive writes
    q = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'hFA, 8'h7E}; push_list(q);
    wr_cyc.delete();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1); in_valid = 1'b0;
    wait_done();
    chk("plain_nwr", wr_cyc.size(), 32'd6);
    if (wr_cyc.size() == 6) chk("plain_span", wr_cyc[5] - wr_cyc[0], 32'd5);
    chk("plain_fc", {16'b0, frame_count}, 32'd1);

    // Payload escapes
    q = '{8'h7E, 8'h7D, 8'h5E, 8'h82, 8'h7E}; push_list(q);
    send(8'h7E, 1'b1);
    chk("esc_ready_low", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0; wait_done();
    q = '{8'h7E, 8'h7D, 8'h5D, 8'h83, 8'h7E}; push_list(q);
    send(8'h7D, 1'b1); in_valid = 1'b0; wait_done();

    // Checksum escapes
    q = '{8'h7E, 8'h82, 8'h7D, 8'h5E, 8'h7E}; push_list(q);
    send(8'h82, 1'b1); in_valid = 1'b0; wait_done();
    q = '{8'h7E, 8'h83, 8'h7D, 8'h5D, 8'h7E}; push_list(q);
    send(8'h83, 1'b1); in_valid = 1'b0; wait_done();
    chk("esc_fc", {16'b0, frame_count}, 32'd5);

    // Backpressure after byte 04 of 01..08
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}; push_frame(q);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    in_data = 8'h05;
    stall3("bp");
    for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
    in_valid = 1'b0; wait_done();

    // Backpressure held across the ESC state
    q = '{8'h11, 8'h7D, 8'h22}; push_frame(q);
    send(8'h11, 1'b0); send(8'h7D, 1'b0);
    stall3("bp_esc");
    send(8'h22, 1'b1); in_valid = 1'b0; wait_done();
    chk("bp_fc", {16'b0, frame_count}, 32'd7);

    // Reset after payload byte 2 of 5
    q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50}; push_frame(q);
    send(8'h10, 1'b0); send(8'h20, 1'b0);
    in_valid = 1'b0; srst = 1'b1;
    @(posedge clk); #1; srst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_fc", {16'b0, frame_count}, 32'd0);
    chk("mid_rst_wr", {31'b0, fifo_wr_en}, 32'd0);
    @(posedge clk); #1;
    q = '{8'h7E, 8'h05, 8'h06, 8'hF5, 8'h7E}; push_list(q);
    send(8'h05, 1'b0); send(8'h06, 1'b1); in_valid = 1'b0; wait_done();
    chk("post_rst_fc", {16'b0, frame_count}, 32'd1);

    // Back-to-back frames with in_valid held high
    srst = 1'b1; @(posedge clk); #1; srst = 1'b0;
    q = '{8'h7E, 8'hAA, 8'h56, 8'h7E, 8'h7E, 8'h55, 8'hAB, 8'h7E}; push_list(q);
    wr_cyc.delete();
    send(8'hAA, 1'b1); send(8'h55, 1'b1); in_valid = 1'b0; wait_done();
    chk("b2b_fc", {16'b0, frame_count}, 32'd2);
    chk("b2b_nwr", wr_cyc.size(), 32'd8);

    // frame_count wrap
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_count;
    @(negedge clk);
    chk("wrap_pre", {16'b0, frame_count}, 32'h0000_FFFF);
    @(posedge clk); #1;
    q = '{8'h09}; push_frame(q);
    send(8'h09, 1'b1); in_valid = 1'b0; wait_done();
    chk("wrap_fc", {16'b0, frame_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_frame_tx.md
# fifo_frame_tx

Upstream framing stage that feeds the 8-bit, 256-entry byte FIFO. It accepts a payload byte stream from the producer over a valid/ready handshake and wraps each frame as flag, escaped payload, escaped checksum, flag. The framed bytes are written into the FIFO under `full` backpressure. Frame boundaries and integrity are recoverable downstream even though the FIFO read side delays unpredictably.

## Interface
- `FLAG`, default 8'h7E: frame delimiter byte.
- `ESC`, default 8'h7D: escape prefix byte.
- `ESC_XOR`, default 8'h20: XOR mask applied to an escaped byte.
- `clk` in 1: system clock. One clock domain only.
- `srst` in 1: reset, synchronous and active-high.
- `in_data` in 8: payload byte.
- `in_valid` in 1: `in_data` / `in_last` are valid.
- `in_last` in 1: current byte is the final payload byte of the frame.
- `in_ready` out 1: the block accepts the byte this cycle.
- `fifo_din` out 8: byte to the FIFO `din`.
- `fifo_wr_en` out 1: to the FIFO `wr_en`.
- `fifo_full` in 1: from the FIFO `full`.
- `busy` out 1: the block is mid-frame (state is not IDLE).
- `frame_count` out 16: number of completed frames, wraps 0xFFFF→0.

## Operation
- **Handshake:** a byte transfers when `in_valid && in_ready`.
- **Write rule:** `fifo_wr_en` is combinational and always gated by `!fifo_full`. It is never asserted while `fifo_full=1`. Every asserted cycle is exactly one byte written.
- **Checksum register `csum`** (8 bit):
  - Cleared on the SOF write.
  - On each accepted payload byte, `csum <= csum + in_data` mod 256.
  - The transmitted checksum `c = (~csum + 1)` mod 256, so that (payload sum + c) mod 256 = 0.
- **Escape rule:** a byte equal to `FLAG` or `ESC` (payload or checksum) is sent as `ESC`, then `byte ^ ESC_XOR`.
- **FSM states:**
  - **IDLE:** `in_ready=0`. If `in_valid && !fifo_full`: write `FLAG`, clear `csum`, go to DATA.
  - **DATA:** `in_ready = !fifo_full`. On transfer of byte b:
    - If b is `FLAG` or `ESC`: write `ESC`, latch `esc_byte = b^ESC_XOR` and `last_q = in_last`, go to ESC.
    - Otherwise: write b, then go to CSUM if `in_last`, else stay in DATA.
  - **ESC:** `in_ready=0`. When `!fifo_full`: write `esc_byte`, then go to CSUM if `last_q`, else DATA.
  - **CSUM:** `in_ready=0`. When `!fifo_full`:
    - If c needs escape: write `ESC`, go to CSUM_ESC.
    - Otherwise: write c, go to EOF.
  - **CSUM_ESC:** when `!fifo_full`: write `c^ESC_XOR`, go to EOF.
  - **EOF:** when `!fifo_full`: write `FLAG`, increment `frame_count`, go to IDLE.
- **Stalls:** while `fifo_full=1` in any state, the state, `csum` and latches hold, and `in_ready=0`.
- **Frame length:** the minimum frame is one payload byte, because `in_last` always accompanies a byte. No empty frames exist.
- **Adjacent frames:** back-to-back frames each carry their own opening and closing `FLAG`. Flags are never shared.
- **Reset values:** `in_ready=0`, `fifo_wr_en=0`, `fifo_din=0`, `busy=0`, `frame_count=0`; state IDLE; `csum=0`.
- **Reset mid-frame:** the partial frame is abandoned. No closing `FLAG` is written, and `frame_count` is cleared. The FIFO is reset by the same `srst`, so its contents are discarded too.
- **Don't-cares:** `fifo_din` is a don't-care when `fifo_wr_en=0`, but drive it to 0.

## Timing
- **Zero-latency write path:** `fifo_din` / `fifo_wr_en` are combinational from state, the latches, `in_*` and `fifo_full`. An accepted payload byte is written in the same cycle it transfers, unless it is escaped, in which case `ESC` is written that cycle.
- **FIFO-side timing:** the FIFO registers the write at the same `clk` edge. Its `full` responds combinationally to its counter, so there is no overrun.
- **Cycle cost per frame**, with `fifo_full` never asserted:
  - 1 cycle for SOF.
  - 1 cycle per unescaped payload byte, 2 per escaped payload byte.
  - 1 or 2 cycles for the checksum.
  - 1 cycle for EOF.
- **`in_ready` timing:**
  - The first payload byte can be accepted at the earliest in the cycle after the SOF write.
  - `in_ready` drops for exactly one cycle after each escaped byte, absent backpressure.
- **`frame_count` timing:** it updates on the clock edge that completes the EOF write.

## Test plan
- **Plain frame:** payload 01,02,03 (last on 03), `fifo_full=0` → FIFO receives 7E 01 02 03 FA 7E in 6 consecutive write cycles. `frame_count` 0→1.
- **Payload escape:** payload 7E (last) → 7E 7D 5E 82 7E. `in_ready` is low in the ESC cycle. A payload of 7D alone → 7E 7D 5D 83 7E.
- **Checksum escape:** payload 82 (last) → checksum 7E → 7E 82 7D 5E 7E. Payload 83 → 7E 83 7D 5D 7E.
- **Backpressure:** during 01..08, force `fifo_full=1` for 3 cycles after byte 04, including across an ESC state. Required response:
  - `fifo_wr_en=0` and `in_ready=0` throughout the stall.
  - No byte is lost or duplicated.
  - The output stream is identical to the unstalled run.
- **Back-to-back frames and wrap:**
  - Frames {AA} and {55} with `in_valid` held high → 7E AA 56 7E 7E 55 AB 7E, `frame_count=2`.
  - Preload `frame_count` to FFFF via 65535 frames (or force) → the next frame gives 0000.
- **Reset mid-frame:** assert `srst` for 1 cycle after payload byte 2 of 5. Required response:
  - The next cycle shows `busy=0`, `frame_count=0`, `fifo_wr_en=0`.
  - A new frame starts cleanly with 7E and a correct checksum.
